// File: rtl/split_bus_arbiter_if.sv
// split_bus_arbiter_if -- bus-side signal bundle for split_bus_arbiter.
//   m_req       : per-master bus request
//   bus_free    : high while no master drives the bus
//   s_split     : per-slave, high while the slave holds a split transaction
//   m_grant     : one-hot grant (all zero when none)
//   s_resume    : one-cycle resume pulse per slave
//   cur_mid     : current bus owner id, all ones when none
//   timeout_err : one-cycle pulse when a granted master never took the bus
// Modports: master = the bus/master side driving requests, slave = the arbiter.
interface split_bus_arbiter_if #(
  parameter int N_MASTERS = 12,
  parameter int N_SLAVES  = 6,
  parameter int MID_W     = $clog2(N_MASTERS + 1)
);
  logic [N_MASTERS-1:0] m_req;
  logic                 bus_free;
  logic [N_SLAVES-1:0]  s_split;
  logic [N_MASTERS-1:0] m_grant;
  logic [N_SLAVES-1:0]  s_resume;
  logic [MID_W-1:0]     cur_mid;
  logic                 timeout_err;

  modport master (output m_req, bus_free, s_split,
                  input  m_grant, s_resume, cur_mid, timeout_err);
  modport slave  (input  m_req, bus_free, s_split,
                  output m_grant, s_resume, cur_mid, timeout_err);
endinterface

// File: rtl/split_bus_arbiter.sv
// split_bus_arbiter -- grouped-priority bus arbiter with split-transaction
// tracking. Masters are split into N_GROUPS groups of consecutive ids
// (group 0 highest), round-robin inside a group. A slave raising s_split
// parks the current owner (blocked) until the slave finishes, after which
// that owner is re-granted and the slave gets an s_resume pulse.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : split_bus_arbiter_if.slave (m_req, bus_free, s_split in;
//          m_grant, s_resume, cur_mid, timeout_err out)
module split_bus_arbiter #(
  parameter int N_MASTERS    = 12,
  parameter int N_GROUPS     = 3,
  parameter int N_SLAVES     = 6,
  parameter int PICK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rstn,
  split_bus_arbiter_if.slave  bus
);
  localparam int MID_W = $clog2(N_MASTERS + 1);
  localparam int GS    = N_MASTERS / N_GROUPS;
  localparam int LW    = (GS > 1) ? $clog2(GS) : 1;
  localparam int GW    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int SW    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int TW    = (PICK_TIMEOUT > 1) ? $clog2(PICK_TIMEOUT) : 1;
  localparam logic [MID_W-1:0] MID_NONE = '1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_WAIT_FREE, S_GRANT, S_RESUME} state_t;
  typedef enum logic [1:0] {T_FREE, T_BUSY, T_DONE} trk_t;

  state_t               state;
  trk_t                 trk_st  [N_SLAVES];
  logic [MID_W-1:0]     trk_own [N_SLAVES];
  logic [LW-1:0]        rr_next [N_GROUPS];   // local index where the next search starts
  logic [N_MASTERS-1:0] blocked;
  logic [MID_W-1:0]     grant_id, cur_mid, cand;
  logic                 cand_res;
  logic [SW-1:0]        cand_sid;
  logic [TW-1:0]        to_cnt;
  logic                 split_pend;           // owner split away, drop cur_mid once bus frees
  logic [N_SLAVES-1:0]  s_resume_q;
  logic                 timeout_q;

  logic [N_MASTERS-1:0] req_eff, grant_dec;
  logic [N_SLAVES-1:0]  split_enter;
  logic                 done_any, req_any, hi_req;
  logic [SW-1:0]        done_sid;
  logic [MID_W-1:0]     req_mid;
  logic [GW-1:0]        cand_grp;
  logic [LW-1:0]        cand_nxt;

  always_comb begin
    int idx;
    idx         = 0;
    req_eff     = bus.m_req & ~blocked;
    split_enter = '0;
    for (int s = 0; s < N_SLAVES; s++)
      split_enter[s] = (trk_st[s] == T_FREE) && bus.s_split[s];

    // lowest-index DONE slave wins (descending loop, last hit sticks)
    done_any = 1'b0;
    done_sid = '0;
    for (int s = N_SLAVES - 1; s >= 0; s--)
      if (trk_st[s] == T_DONE) begin
        done_any = 1'b1;
        done_sid = SW'(s);
      end

    // highest group, then first requester in rotation order from rr_next
    req_any = 1'b0;
    req_mid = MID_NONE;
    for (int g = N_GROUPS - 1; g >= 0; g--)
      for (int k = GS - 1; k >= 0; k--) begin
        idx = (int'(rr_next[g]) + k) % GS;
        if (req_eff[MID_W'(g * GS + idx)]) begin
          req_any = 1'b1;
          req_mid = MID_W'(g * GS + idx);
        end
      end

    // only a strictly higher group may pre-empt the current owner
    hi_req = 1'b0;
    for (int m = 0; m < N_MASTERS; m++)
      if (req_eff[m] && ((int'(cur_mid) >= N_MASTERS) || ((m / GS) < (int'(cur_mid) / GS))))
        hi_req = 1'b1;

    grant_dec = '0;
    for (int m = 0; m < N_MASTERS; m++)
      grant_dec[m] = (grant_id == MID_W'(m));

    cand_grp = GW'(int'(cand) / GS);
    cand_nxt = LW'(((int'(cand) % GS) + 1) % GS);
  end

  assign bus.m_grant     = grant_dec;
  assign bus.s_resume    = s_resume_q;
  assign bus.cur_mid     = cur_mid;
  assign bus.timeout_err = timeout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      grant_id   <= MID_NONE;
      cur_mid    <= MID_NONE;
      cand       <= MID_NONE;
      cand_res   <= 1'b0;
      cand_sid   <= '0;
      to_cnt     <= '0;
      split_pend <= 1'b0;
      blocked    <= '0;
      s_resume_q <= '0;
      timeout_q  <= 1'b0;
      for (int s = 0; s < N_SLAVES; s++) begin
        trk_st[s]  <= T_FREE;
        trk_own[s] <= MID_NONE;
      end
      for (int g = 0; g < N_GROUPS; g++) rr_next[g] <= '0;
    end else begin
      s_resume_q <= '0;
      timeout_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.bus_free) begin
            cur_mid  <= MID_NONE;
            grant_id <= MID_NONE;
          end
          if (done_any || hi_req) state <= S_ARB;
        end
        S_ARB: begin
          if (done_any) begin
            cand     <= trk_own[done_sid];
            cand_res <= 1'b1;
            cand_sid <= done_sid;
            // a split taken while nobody owned the bus has no one to re-grant:
            // just release the slave
            if (int'(trk_own[done_sid]) >= N_MASTERS) state <= S_RESUME;
            else begin
              grant_id <= MID_NONE;
              state    <= S_WAIT_FREE;
            end
          end else if (req_any) begin
            cand     <= req_mid;
            cand_res <= 1'b0;
            grant_id <= MID_NONE;
            state    <= S_WAIT_FREE;
          end else begin
            state <= S_IDLE;  // requester vanished; keep the present owner's grant
          end
        end
        S_WAIT_FREE: begin
          if (bus.bus_free) begin
            grant_id <= cand;
            to_cnt   <= '0;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!bus.bus_free) begin
            cur_mid           <= cand;
            rr_next[cand_grp] <= cand_nxt;
            state             <= cand_res ? S_RESUME : S_IDLE;
          end else if (to_cnt == TW'(PICK_TIMEOUT - 1)) begin
            // tracker of a resume candidate stays DONE, so it is retried
            grant_id          <= MID_NONE;
            timeout_q         <= 1'b1;
            rr_next[cand_grp] <= cand_nxt;
            state             <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RESUME: begin
          s_resume_q[cand_sid] <= 1'b1;
          trk_st[cand_sid]     <= T_FREE;
          trk_own[cand_sid]    <= MID_NONE;
          if (int'(cand) < N_MASTERS) blocked[cand] <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // split tracking runs in every state; placed last so a new split wins
      for (int s = 0; s < N_SLAVES; s++) begin
        if (split_enter[s]) begin
          trk_st[s]  <= T_BUSY;
          trk_own[s] <= cur_mid;
        end else if (trk_st[s] == T_BUSY && !bus.s_split[s]) begin
          trk_st[s] <= T_DONE;
        end
      end
      if (|split_enter) begin
        grant_id <= MID_NONE;
        if (int'(cur_mid) < N_MASTERS) blocked[cur_mid] <= 1'b1;
      end
      split_pend <= (|split_enter) || (split_pend && !bus.bus_free);
      if (split_pend && bus.bus_free) cur_mid <= MID_NONE;
    end
  end
endmodule

// File: tb/tb_split_bus_arbiter.sv
// tb_split_bus_arbiter -- directed self-checking bench for split_bus_arbiter
// (12 masters in 3 groups of 4, 6 slaves, pickup timeout 8).
module tb_split_bus_arbiter;
  localparam logic [3:0] NONE = 4'hF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  split_bus_arbiter_if #(.N_MASTERS(12), .N_SLAVES(6)) bus ();

  split_bus_arbiter #(
    .N_MASTERS(12), .N_GROUPS(3), .N_SLAVES(6), .PICK_TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.m_req    = '0;
    bus.s_split  = '0;
    bus.bus_free = 1'b1;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // from idle with a free bus: request, wait the 3-cycle grant, take the bus
  task automatic grant_to(input int mid);
    bus.m_req = 12'(1) << mid;
    tick(); tick(); tick();
    bus.bus_free = 1'b0;
    bus.m_req    = '0;
    tick();
  endtask

  task automatic test_reset();
    bus.m_req = '0; bus.s_split = '0; bus.bus_free = 1'b1;
    rstn = 1'b0;
    tick();
    n_cmp++; if (bus.m_grant !== 12'h0)   begin n_bad++; $display("FAIL reset_grant: got %h want 000", bus.m_grant); end
    n_cmp++; if (bus.cur_mid !== NONE)    begin n_bad++; $display("FAIL reset_cur_mid: got %h want f", bus.cur_mid); end
    n_cmp++; if (bus.s_resume !== 6'h0)   begin n_bad++; $display("FAIL reset_resume: got %h want 00", bus.s_resume); end
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_err); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic_grant();
    do_reset();
    bus.m_req = 12'h020;
    tick();
    n_cmp++; if (bus.m_grant !== 12'h000) begin n_bad++; $display("FAIL basic_early: got %h want 000", bus.m_grant); end
    tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h020) begin n_bad++; $display("FAIL basic_grant: got %h want 020", bus.m_grant); end
    bus.bus_free = 1'b0;
    bus.m_req    = '0;
    tick();
    n_cmp++; if (bus.cur_mid !== 4'd5)    begin n_bad++; $display("FAIL basic_owner: got %h want 5", bus.cur_mid); end
    n_cmp++; if (bus.m_grant !== 12'h020) begin n_bad++; $display("FAIL basic_hold: got %h want 020", bus.m_grant); end
  endtask

  task automatic test_preempt();
    do_reset();
    grant_to(5);
    bus.m_req = 12'h002;
    tick();
    n_cmp++; if (bus.m_grant !== 12'h020) begin n_bad++; $display("FAIL preempt_arb: got %h want 020", bus.m_grant); end
    tick();
    n_cmp++; if (bus.m_grant !== 12'h000) begin n_bad++; $display("FAIL preempt_withdraw: got %h want 000", bus.m_grant); end
    bus.bus_free = 1'b1;
    tick();
    n_cmp++; if (bus.m_grant !== 12'h002) begin n_bad++; $display("FAIL preempt_grant: got %h want 002", bus.m_grant); end
    bus.bus_free = 1'b0;
    bus.m_req    = '0;
    tick();
    n_cmp++; if (bus.cur_mid !== 4'd1)    begin n_bad++; $display("FAIL preempt_owner: got %h want 1", bus.cur_mid); end
    // lower group cannot pre-empt
    do_reset();
    grant_to(5);
    bus.m_req = 12'h200;
    tick(); tick(); tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h020) begin n_bad++; $display("FAIL low_group_grant: got %h want 020", bus.m_grant); end
    n_cmp++; if (bus.cur_mid !== 4'd5)    begin n_bad++; $display("FAIL low_group_owner: got %h want 5", bus.cur_mid); end
    bus.m_req = '0;
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_g [4];
    logic [3:0]  exp_m [4];
    exp_g = '{12'h001, 12'h002, 12'h001, 12'h002};
    exp_m = '{4'd0, 4'd1, 4'd0, 4'd1};
    do_reset();
    bus.m_req = 12'h003;
    for (int i = 0; i < 4; i++) begin
      tick(); tick(); tick();
      n_cmp++; if (bus.m_grant !== exp_g[i]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %h want %h", i, bus.m_grant, exp_g[i]); end
      bus.bus_free = 1'b0;
      tick();
      n_cmp++; if (bus.cur_mid !== exp_m[i]) begin n_bad++; $display("FAIL rr_owner[%0d]: got %h want %h", i, bus.cur_mid, exp_m[i]); end
      bus.bus_free = 1'b1;
      tick();
    end
    bus.m_req = '0;
  endtask

  task automatic test_split();
    do_reset();
    grant_to(2);
    bus.m_req   = 12'h004;
    bus.s_split = 6'h08;
    tick();
    n_cmp++; if (bus.m_grant !== 12'h000) begin n_bad++; $display("FAIL split_grant_drop: got %h want 000", bus.m_grant); end
    bus.bus_free = 1'b1;
    tick();
    n_cmp++; if (bus.cur_mid !== NONE)    begin n_bad++; $display("FAIL split_owner_clear: got %h want f", bus.cur_mid); end
    tick(); tick(); tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h000) begin n_bad++; $display("FAIL split_blocked_req: got %h want 000", bus.m_grant); end
    bus.s_split = 6'h00;
    tick(); tick(); tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h004) begin n_bad++; $display("FAIL split_regrant: got %h want 004", bus.m_grant); end
    bus.bus_free = 1'b0;
    tick();
    n_cmp++; if (bus.cur_mid !== 4'd2)    begin n_bad++; $display("FAIL split_owner: got %h want 2", bus.cur_mid); end
    n_cmp++; if (bus.s_resume !== 6'h00)  begin n_bad++; $display("FAIL split_resume_early: got %h want 00", bus.s_resume); end
    tick();
    n_cmp++; if (bus.s_resume !== 6'h08)  begin n_bad++; $display("FAIL split_resume: got %h want 08", bus.s_resume); end
    tick();
    n_cmp++; if (bus.s_resume !== 6'h00)  begin n_bad++; $display("FAIL split_resume_pulse: got %h want 00", bus.s_resume); end
    // unblocked again: the still-pending request is served normally
    bus.bus_free = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h004) begin n_bad++; $display("FAIL split_unblocked: got %h want 004", bus.m_grant); end
    bus.m_req = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    grant_to(6);
    bus.bus_free = 1'b1;
    tick();
    bus.m_req = 12'h090;
    tick(); tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h080) begin n_bad++; $display("FAIL to_grant7: got %h want 080", bus.m_grant); end
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (bus.m_grant !== 12'h080 || bus.timeout_err !== 1'b0)
      begin n_bad++; $display("FAIL to_early: got grant %h err %b want 080 0", bus.m_grant, bus.timeout_err); end
    tick();
    n_cmp++; if (bus.timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", bus.timeout_err); end
    n_cmp++; if (bus.m_grant !== 12'h000)  begin n_bad++; $display("FAIL to_clear: got %h want 000", bus.m_grant); end
    tick();
    n_cmp++; if (bus.timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse_end: got %b want 0", bus.timeout_err); end
    tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h010)  begin n_bad++; $display("FAIL to_next: got %h want 010", bus.m_grant); end
    bus.m_req = '0;
  endtask

  task automatic test_reset_mid();
    logic bad;
    do_reset();
    grant_to(2);
    bus.s_split = 6'h03;
    tick();
    bus.bus_free = 1'b1;
    tick();
    bus.m_req = 12'h020;
    tick(); tick(); tick();
    n_cmp++; if (bus.m_grant !== 12'h020) begin n_bad++; $display("FAIL rmid_pre_grant: got %h want 020", bus.m_grant); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (bus.m_grant !== 12'h000) begin n_bad++; $display("FAIL rmid_grant: got %h want 000", bus.m_grant); end
    n_cmp++; if (bus.cur_mid !== NONE)    begin n_bad++; $display("FAIL rmid_cur_mid: got %h want f", bus.cur_mid); end
    n_cmp++; if (bus.s_resume !== 6'h00 || bus.timeout_err !== 1'b0)
      begin n_bad++; $display("FAIL rmid_pulses: got %h %b want 00 0", bus.s_resume, bus.timeout_err); end
    bus.m_req   = '0;
    bus.s_split = '0;
    tick(); tick();
    rstn = 1'b1;
    bad  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.s_resume !== 6'h00 || bus.m_grant !== 12'h000) bad = 1'b1;
    end
    n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resume: got activity %b want 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    bus.m_req = '0; bus.s_split = '0; bus.bus_free = 1'b1;
    test_reset();
    test_basic_grant();
    test_preempt();
    test_round_robin();
    test_split();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/split_bus_arbiter.md
SPLIT_BUS_ARBITER -- requirements
Module: split_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 12: number of bus masters.
REQ-002 SHALL have parameter N_GROUPS, default 3: number of priority groups, each of N_MASTERS/N_GROUPS consecutive masters; group 0 is highest priority; N_MASTERS SHALL be a multiple of N_GROUPS.
REQ-003 SHALL have parameter N_SLAVES, default 6: number of split-capable slaves.
REQ-004 SHALL have parameter PICK_TIMEOUT, default 8: cycles allowed for a granted master to take the bus.
REQ-005 SHALL define MID_W = $clog2(N_MASTERS+1) and MID_NONE = all ones of MID_W.
REQ-006 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port m_req, input, N_MASTERS: bus request per master.
REQ-009 SHALL have port bus_free, input, 1: high when no master drives the bus.
REQ-010 SHALL have port s_split, input, N_SLAVES: high while the slave holds a split transaction.
REQ-011 SHALL have port m_grant, output, N_MASTERS: one-hot grant, all zero when none.
REQ-012 SHALL have port s_resume, output, N_SLAVES: one-cycle resume pulse to a slave.
REQ-013 SHALL have port cur_mid, output, MID_W: current bus owner, MID_NONE if none.
REQ-014 SHALL have port timeout_err, output, 1: one-cycle pulse on grant pickup timeout.

Function
REQ-015 m_grant SHALL be a combinational one-hot decode of the registered grant_id; all zero when grant_id >= N_MASTERS.
REQ-016 Each slave tracker SHALL hold a state (FREE, BUSY, DONE) and an owner MID: FREE with s_split=1 -> BUSY, owner <= cur_mid, blocked[cur_mid] <= 1; BUSY with s_split=0 -> DONE. These updates SHALL occur in every FSM state.
REQ-017 If several slaves enter BUSY in the same cycle, all SHALL be recorded with the same owner.
REQ-018 Requests from blocked masters SHALL be ignored.
REQ-019 On any slave entering BUSY, grant_id SHALL go to MID_NONE next cycle; cur_mid SHALL go to MID_NONE when bus_free is next high.
REQ-020 The FSM SHALL have states IDLE, ARB, WAIT_FREE, GRANT, RESUME.
REQ-021 IDLE -> ARB when any tracker is DONE, or an unblocked request exists in a group strictly higher than cur_mid's group (any group if cur_mid = MID_NONE); otherwise stay. In IDLE, bus_free=1 SHALL clear cur_mid and grant_id.
REQ-022 ARB (1 cycle) SHALL select the lowest-index DONE slave (cand = its owner, resume flag = 1); else the highest-priority group with a request, round-robin starting after that group's last-granted master (resume flag = 0). It then goes to WAIT_FREE.
REQ-023 WAIT_FREE SHALL drive grant_id = MID_NONE and wait for bus_free=1, then go to GRANT.
REQ-024 GRANT SHALL drive grant_id = cand. Once bus_free=0, it SHALL set cur_mid = cand and update the group round-robin pointer, then go to RESUME if the resume flag is set, else IDLE.
REQ-025 If bus_free stays 1 for PICK_TIMEOUT cycles in GRANT, the block SHALL clear grant_id, pulse timeout_err, advance the round-robin pointer past cand, and return to IDLE; a resume candidate SHALL stay DONE and be retried.
REQ-026 RESUME (1 cycle) SHALL pulse s_resume[sid], set tracker sid to FREE with owner MID_NONE, clear blocked[cand], and return to IDLE.
REQ-027 Latency SHALL be: unblocked request on free bus -> m_grant asserted in 3 cycles (IDLE, ARB, WAIT_FREE).

Reset
REQ-028 rstn low SHALL immediately force the FSM to IDLE, cur_mid and grant_id to MID_NONE, m_grant, s_resume and timeout_err to 0, all trackers FREE/MID_NONE, blocked to 0, and round-robin pointers to 0, even mid-transaction.

Verification
REQ-029 m_req[5]=1, bus_free=1 -> m_grant=0x020 at cycle 3; bus_free drops -> cur_mid=5.
REQ-030 cur_mid=5 (group 1) and m_req[1]=1 -> grant withdrawn, m_grant=0x002 after bus_free=1; m_req[9] alone while cur_mid=5 -> no grant.
REQ-031 Masters 0 and 1 requesting repeatedly -> grants alternate 0,1,0,1.
REQ-032 Master 2 owns the bus, s_split[3] rises then falls -> blocked[2]=1, m_req[2] ignored; after fall -> master 2 granted, s_resume[3] one-cycle pulse, blocked[2]=0.
REQ-033 Grant to master 7 with bus_free held 1 for 8 cycles -> timeout_err pulse, m_grant=0, next grant goes to another requester in the group.
REQ-034 rstn low during GRANT with two BUSY trackers -> all outputs at reset values immediately; no s_resume after release.
